// File: rtl/data_transmitter.sv
// Byte serializer: captures a result word from the core and hands it out
// one OUT_WIDTH chunk per rising data_request, most-significant chunk first.
module data_transmitter #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_data_ready,
    input  logic                 data_request,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_data_ready
);

    localparam int NUM_CHUNKS = IN_WIDTH / OUT_WIDTH;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    typedef enum logic [1:0] {IDLE, ARMED, SENDING} state_t;

    state_t               state_q, state_d;
    logic [IN_WIDTH-1:0]  buf_q, buf_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 req_prev_q;
    logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic                 out_rdy_q, out_rdy_d;

    logic                 req;
    logic                 last_chunk;
    logic [IN_WIDTH-1:0]  first_word;
    logic [IN_WIDTH-1:0]  shifted;

    assign req        = data_request & ~req_prev_q;
    assign last_chunk = (idx_q == IDX_W'(NUM_CHUNKS - 1));
    // Byte 0 prefers the live input so a word settling on the request cycle is not missed.
    assign first_word = in_data_ready ? in_data : buf_q;
    assign shifted    = buf_q << (OUT_WIDTH * idx_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            buf_q      <= '0;
            idx_q      <= '0;
            req_prev_q <= 1'b0;
            out_data_q <= '0;
            out_rdy_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            idx_q      <= idx_d;
            req_prev_q <= data_request;
            out_data_q <= out_data_d;
            out_rdy_q  <= out_rdy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_data_ready) state_d = ARMED;
            ARMED:   if (req) state_d = (NUM_CHUNKS == 1) ? IDLE : SENDING;
            SENDING: if (req && last_chunk) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        buf_d      = buf_q;
        idx_d      = idx_q;
        out_data_d = out_data_q;
        out_rdy_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_data_ready) buf_d = in_data;
            end
            ARMED: begin
                if (req) begin
                    buf_d      = first_word;
                    out_data_d = first_word[IN_WIDTH-1 -: OUT_WIDTH];
                    out_rdy_d  = 1'b1;
                    idx_d      = (NUM_CHUNKS == 1) ? '0 : IDX_W'(1);
                end else if (in_data_ready) begin
                    buf_d = in_data;
                end
            end
            SENDING: begin
                if (req) begin
                    out_data_d = shifted[IN_WIDTH-1 -: OUT_WIDTH];
                    out_rdy_d  = 1'b1;
                    idx_d      = last_chunk ? '0 : idx_q + IDX_W'(1);
                end
            end
            default: begin
                idx_d = '0;
            end
        endcase
    end

    assign out_data       = out_data_q;
    assign out_data_ready = out_rdy_q;

endmodule

// File: tb/tb_data_transmitter.sv
// Bench for data_transmitter: a per-cycle vector table for reset, late data
// and a full word, then scoreboarded sequences for the multi-cycle corner cases.
module tb_data_transmitter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_data_ready;
    logic        data_request;
    logic [7:0]  out_data;
    logic        out_data_ready;

    int n_chk  = 0;
    int n_fail = 0;
    bit sb_en  = 1'b0;
    logic [7:0] sb_q[$];

    always #5 clk = ~clk;

    data_transmitter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_data        (in_data),
        .in_data_ready  (in_data_ready),
        .data_request   (data_request),
        .out_data       (out_data),
        .out_data_ready (out_data_ready)
    );

    typedef struct {
        logic        rst_n;
        logic [31:0] in_data;
        logic        in_rdy;
        logic        req;
        logic        exp_rdy;
        logic [7:0]  exp_out;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req_pulse(input logic [7:0] exp);
        sb_q.push_back(exp);
        data_request = 1'b1;
        step();
        data_request = 1'b0;
        step();
    endtask

    // Scoreboard: every strobe must match the next expected byte.
    always @(negedge clk) begin
        if (sb_en && rst_n && out_data_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_strobe", {24'h0, out_data}, 32'hFFFF_FFFF);
            end else begin
                chk("sb_byte", {24'h0, out_data}, {24'h0, sb_q.pop_front()});
            end
        end
    end

    function automatic vec_t mk(logic r, logic [31:0] d, logic rdy, logic q, logic er, logic [7:0] eo);
        vec_t v;
        v.rst_n = r; v.in_data = d; v.in_rdy = rdy; v.req = q; v.exp_rdy = er; v.exp_out = eo;
        return v;
    endfunction

    initial begin
        vecs[0]  = mk(0, 32'hDEADBEEF, 1, 1, 0, 8'h00);
        vecs[1]  = mk(0, 32'h12345678, 0, 1, 0, 8'h00);
        vecs[2]  = mk(1, 32'h0,        0, 0, 0, 8'h00);
        vecs[3]  = mk(1, 32'h0,        0, 1, 0, 8'h00); // request with no data
        vecs[4]  = mk(1, 32'h0,        0, 0, 0, 8'h00);
        vecs[5]  = mk(1, 32'h0,        1, 0, 0, 8'h00);
        vecs[6]  = mk(1, 32'h009BC656, 1, 0, 0, 8'h00); // late data
        vecs[7]  = mk(1, 32'h009BC656, 1, 1, 1, 8'h00);
        vecs[8]  = mk(1, 32'h009BC656, 1, 1, 0, 8'h00); // level held: no second strobe
        vecs[9]  = mk(1, 32'h009BC656, 1, 0, 0, 8'h00);
        vecs[10] = mk(1, 32'h009BC656, 1, 1, 1, 8'h9B);
        vecs[11] = mk(1, 32'h009BC656, 1, 0, 0, 8'h9B);
        vecs[12] = mk(1, 32'h009BC656, 1, 1, 1, 8'hC6);
        vecs[13] = mk(1, 32'h009BC656, 1, 0, 0, 8'hC6);
        vecs[14] = mk(1, 32'h009BC656, 1, 1, 1, 8'h56);
        vecs[15] = mk(1, 32'h009BC656, 1, 0, 0, 8'h56);
        vecs[16] = mk(1, 32'hCAFEF00D, 1, 0, 0, 8'h56); // re-armed, tracking new word
        vecs[17] = mk(1, 32'hCAFEF00D, 1, 1, 1, 8'hCA);
        vecs[18] = mk(1, 32'hCAFEF00D, 1, 0, 0, 8'hCA);

        rst_n = 1'b0; in_data = '0; in_data_ready = 1'b0; data_request = 1'b0;
        step();
        for (int i = 0; i < 19; i++) begin
            rst_n         = vecs[i].rst_n;
            in_data       = vecs[i].in_data;
            in_data_ready = vecs[i].in_rdy;
            data_request  = vecs[i].req;
            step();
            chk($sformatf("vec%0d_rdy", i), {31'h0, out_data_ready}, {31'h0, vecs[i].exp_rdy});
            chk($sformatf("vec%0d_out", i), {24'h0, out_data}, {24'h0, vecs[i].exp_out});
        end

        // Reset with random inputs.
        sb_en = 1'b1;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_data = $urandom; in_data_ready = 1'($urandom); data_request = 1'($urandom);
            step();
            chk("rst_out", {24'h0, out_data}, 32'h0);
            chk("rst_rdy", {31'h0, out_data_ready}, 32'h0);
        end
        rst_n = 1'b1; data_request = 1'b0; in_data_ready = 1'b0;
        step();

        // Input change during SENDING is ignored.
        in_data = 32'h11223344; in_data_ready = 1'b1;
        step();
        req_pulse(8'h11);
        in_data = 32'hAABBCCDD;
        req_pulse(8'h22);
        req_pulse(8'h33);
        req_pulse(8'h44);
        in_data_ready = 1'b0;
        step(); step();
        chk("hold_44", {24'h0, out_data}, 32'h44);
        chk("sb_drain_a", sb_q.size(), 0);

        // Reset mid-word abandons the partial word.
        in_data = 32'h55667788; in_data_ready = 1'b1;
        step();
        req_pulse(8'h55);
        req_pulse(8'h66);
        rst_n = 1'b0;
        step();
        chk("midrst_out", {24'h0, out_data}, 32'h0);
        chk("midrst_rdy", {31'h0, out_data_ready}, 32'h0);
        rst_n = 1'b1; in_data = 32'h01020304; in_data_ready = 1'b1;
        step();
        req_pulse(8'h01);
        req_pulse(8'h02);
        req_pulse(8'h03);
        req_pulse(8'h04);
        step(); step();
        chk("hold_04", {24'h0, out_data}, 32'h04);
        chk("sb_drain_b", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
